// File: rtl/alu_scheduler_if.sv
// Requester-facing request/response bus of the shared PE ALU scheduler.
// Operands and selects are packed per requester: op i in [5i+4:5i], A/B i in [32i+31:32i].
interface alu_scheduler_if #(
   parameter int unsigned NUM_REQ = 4
);
   localparam int unsigned OP_W = 5;
   localparam int unsigned D_W  = 32;

   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0]      req_ready;
   logic [OP_W*NUM_REQ-1:0] req_op;
   logic [D_W*NUM_REQ-1:0]  req_a;
   logic [D_W*NUM_REQ-1:0]  req_b;
   logic [NUM_REQ-1:0]      resp_valid;
   logic [NUM_REQ-1:0]      resp_ready;
   logic [D_W-1:0]          resp_data;
   logic                    resp_zero;
   logic                    resp_cout;
   logic                    resp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_zero, resp_cout, resp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_data, resp_zero, resp_cout, resp_err
   );
endinterface

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one registered PE ALU among NUM_REQ requesters,
// with one operation outstanding at a time and wrapping op/error counters.
module alu_scheduler #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   alu_scheduler_if.slave    bus,
   output logic [31:0]       alu_a,
   output logic [31:0]       alu_b,
   output logic [4:0]        alu_sel,
   input  logic [31:0]       alu_out,
   input  logic              alu_complete,
   input  logic              alu_cout,
   output logic              busy,
   output logic [CNT_W-1:0]  op_count,
   output logic [CNT_W-1:0]  err_count
);
   localparam int unsigned IDX_W   = $clog2(NUM_REQ);
   localparam logic [4:0]  SEL_NOP = 5'b11111;

   typedef enum logic [1:0] {IDLE, ISSUE, EXEC, RESP} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   last_grant, grant_idx, cand_idx;
   logic               grant_found, accept;
   logic [NUM_REQ-1:0] ready_c;

   logic [4:0]  op_arr [NUM_REQ];
   logic [31:0] a_arr  [NUM_REQ];
   logic [31:0] b_arr  [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign op_arr[i] = bus.req_op[5*i +: 5];
      assign a_arr[i]  = bus.req_a[32*i +: 32];
      assign b_arr[i]  = bus.req_b[32*i +: 32];
   end

   // Search starts one past the last grant; the last grantee is visited last.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = last_grant;
      cand_idx    = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand_idx = IDX_W'((32'(last_grant) + k) % NUM_REQ);
         if (!grant_found && bus.req_valid[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ready_c = '0;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_found) begin
               ready_c = NUM_REQ'(1) << grant_idx;
               accept  = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE:   state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (bus.resp_ready[last_grant]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.req_ready = ready_c;

   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Issue path: operands latched only on the accepting edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_grant <= IDX_W'(NUM_REQ - 1);
         alu_a      <= '0;
         alu_b      <= '0;
         alu_sel    <= SEL_NOP;
         busy       <= 1'b0;
      end else begin
         busy <= (state_d != IDLE);
         if (accept) begin
            last_grant <= grant_idx;
            alu_a      <= a_arr[grant_idx];
            alu_b      <= b_arr[grant_idx];
            alu_sel    <= op_arr[grant_idx];
         end else if (state_q == EXEC) begin
            alu_sel <= SEL_NOP;
         end
      end
   end

   // Result capture relies on the ALU's single-cycle registered latency.
   always_ff @(posedge clk) begin
      if (!reset) begin
         bus.resp_valid <= '0;
         bus.resp_data  <= '0;
         bus.resp_zero  <= 1'b0;
         bus.resp_cout  <= 1'b0;
         bus.resp_err   <= 1'b0;
         op_count       <= '0;
         err_count      <= '0;
      end else begin
         if (state_q == EXEC) begin
            bus.resp_valid <= NUM_REQ'(1) << last_grant;
            bus.resp_data  <= alu_out;
            bus.resp_zero  <= (alu_out == 32'd0);
            bus.resp_cout  <= alu_cout;
            bus.resp_err   <= ~alu_complete;
            op_count       <= op_count + CNT_W'(1);
            if (!alu_complete) err_count <= err_count + CNT_W'(1);
         end else if (state_q == RESP && state_d == IDLE) begin
            bus.resp_valid <= '0;
         end
      end
   end
endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: behavioural ALU, timestamp-based scheduler model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_alu_scheduler;
   localparam int unsigned NR = 4;
   localparam int unsigned CW = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   alu_scheduler_if #(.NUM_REQ(NR)) bus ();

   logic [31:0]   alu_a, alu_b, alu_out;
   logic [4:0]    alu_sel;
   logic          alu_complete, alu_cout, busy;
   logic [CW-1:0] op_count, err_count;

   alu_scheduler #(.NUM_REQ(NR), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_complete(alu_complete), .alu_cout(alu_cout),
      .busy(busy), .op_count(op_count), .err_count(err_count)
   );

   // Requester operand storage, packed onto the bus.
   logic [4:0]  r_op [NR];
   logic [31:0] r_a  [NR];
   logic [31:0] r_b  [NR];
   always_comb begin
      for (int i = 0; i < NR; i++) begin
         bus.req_op[5*i +: 5]  = r_op[i];
         bus.req_a[32*i +: 32] = r_a[i];
         bus.req_b[32*i +: 32] = r_b[i];
      end
   end

   // {complete, cout, out} of the PE ALU for a given select.
   function automatic logic [33:0] alu_f(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] w;
      logic [31:0] o;
      logic c, ok;
      w = '0; o = '0; c = 1'b0; ok = 1'b1;
      case (s)
         5'd0: begin w = {1'b0, a} + {1'b0, b}; o = w[31:0]; c = w[32]; end
         5'd1: begin w = {1'b0, a} + {1'b0, ~b} + 33'd1; o = w[31:0]; c = w[32]; end
         5'd2: o = a * b;
         5'd3: if (b == 32'd0) begin o = '1; ok = 1'b0; end else o = a / b;
         5'd4: o = a & b;
         5'd5: o = a | b;
         5'd6: o = a ^ b;
         5'd7: o = $signed(a) >>> b[4:0];
         default: ok = 1'b0;
      endcase
      return {ok, c, o};
   endfunction

   always @(posedge clk) {alu_complete, alu_cout, alu_out} <= alu_f(alu_sel, alu_a, alu_b);

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
   endtask

   task automatic timeout(input string nm);
      n_chk++;
      $display("FAIL %s: timed out at t=%0t", nm, $time);
   endtask

   // ---------------- scheduler model ----------------
   function automatic int pick(input logic [NR-1:0] v, input int last);
      for (int k = 1; k <= NR; k++) begin
         int c;
         c = (last + k) % NR;
         if (((v >> c) & NR'(1)) != '0) return c;
      end
      return -1;
   endfunction

   int          cyc = 0;
   bit          m_live = 1'b0;
   bit          m_pend = 1'b0;
   int          m_acc = 0, m_req = 0, m_last = NR - 1;
   int          m_ops = 0, m_errs = 0;
   logic [4:0]  m_op;
   logic [31:0] m_a, m_b;
   logic [33:0] m_res;
   int          g_now;

   always_comb g_now = pick(bus.req_valid, m_last);

   always @(posedge clk) begin
      if (!reset) begin
         m_live <= 1'b1;
         m_pend <= 1'b0;
         m_last <= NR - 1;
         m_ops  <= 0;
         m_errs <= 0;
      end else if (!m_pend) begin
         if (g_now >= 0) begin
            m_pend <= 1'b1;
            m_acc  <= cyc;
            m_req  <= g_now;
            m_last <= g_now;
            m_op   <= r_op[g_now];
            m_a    <= r_a[g_now];
            m_b    <= r_b[g_now];
            m_res  <= alu_f(r_op[g_now], r_a[g_now], r_b[g_now]);
         end
      end else begin
         if (cyc == m_acc + 2) begin
            m_ops <= (m_ops + 1) % (1 << CW);
            if (!m_res[33]) m_errs <= (m_errs + 1) % (1 << CW);
         end
         if (cyc >= m_acc + 3 && ((bus.resp_ready >> m_req) & NR'(1)) != '0) m_pend <= 1'b0;
      end
      cyc <= cyc + 1;
   end

   logic [NR-1:0] e_rdy, e_rv;
   bit            in_alu, in_resp;

   always @(negedge clk) begin
      if (m_live) begin
         in_alu  = m_pend && (cyc <= m_acc + 2);
         in_resp = m_pend && (cyc >= m_acc + 3);
         e_rdy   = (!m_pend && g_now >= 0) ? (NR'(1) << g_now) : '0;
         e_rv    = in_resp ? (NR'(1) << m_req) : '0;
         check("m_req_ready", 32'(bus.req_ready), 32'(e_rdy));
         check("m_resp_valid", 32'(bus.resp_valid), 32'(e_rv));
         check("m_busy", 32'(busy), 32'(m_pend));
         check("m_alu_sel", 32'(alu_sel), in_alu ? 32'(m_op) : 32'h1F);
         check("m_op_count", 32'(op_count), 32'(m_ops));
         check("m_err_count", 32'(err_count), 32'(m_errs));
         if (in_alu) begin
            check("m_alu_a", alu_a, m_a);
            check("m_alu_b", alu_b, m_b);
         end
         if (in_resp) begin
            check("m_resp_data", bus.resp_data, m_res[31:0]);
            check("m_resp_zero", 32'(bus.resp_zero), 32'(m_res[31:0] == 32'd0));
            check("m_resp_cout", 32'(bus.resp_cout), 32'(m_res[32]));
            check("m_resp_err", 32'(bus.resp_err), 32'(!m_res[33]));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic set_req(input int i, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      r_op[i] = op; r_a[i] = a; r_b[i] = b;
      bus.req_valid = bus.req_valid | (NR'(1) << i);
   endtask

   task automatic clr_req(input int i);
      bus.req_valid = bus.req_valid & ~(NR'(1) << i);
   endtask

   // Returns at the negedge of the cycle in which the bit is seen.
   task automatic wait_ready(input int i, input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (((bus.req_ready >> i) & NR'(1)) == '0 && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) timeout(nm);
   endtask

   task automatic wait_resp(input int i, input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (((bus.resp_valid >> i) & NR'(1)) == '0 && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) timeout(nm);
   endtask

   task automatic run_op(input int i, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input string nm);
      set_req(i, op, a, b);
      wait_ready(i, nm);
      @(posedge clk); #1;
      clr_req(i);
      wait_resp(i, nm);
   endtask

   task automatic do_reset();
      bus.req_valid = '0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   int served [NR];
   int g, n;

   initial begin
      bus.req_valid  = '0;
      bus.resp_ready = '1;
      for (int i = 0; i < NR; i++) begin r_op[i] = 5'h1F; r_a[i] = '0; r_b[i] = '0; served[i] = 0; end

      // Reset values
      do_reset();
      @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'h0);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_resp_data", bus.resp_data, 32'h0);
      check("rst_flags", {29'd0, bus.resp_zero, bus.resp_cout, bus.resp_err}, 32'h0);
      check("rst_counts", {24'd0, op_count, err_count}, 32'h0);
      check("rst_alu_ab", alu_a | alu_b, 32'h0);
      check("rst_alu_sel", 32'(alu_sel), 32'h1F);
      @(posedge clk); #1;

      // Single add from req0: ready in N, response in N+3
      set_req(0, 5'd0, 32'd5, 32'd7);
      @(negedge clk);
      check("add_ready", 32'(bus.req_ready), 32'h1);
      @(posedge clk); #1;
      clr_req(0);
      @(negedge clk);
      @(negedge clk);
      check("add_resp_early", 32'(bus.resp_valid), 32'h0);
      @(negedge clk);
      check("add_resp_valid", 32'(bus.resp_valid), 32'h1);
      check("add_data", bus.resp_data, 32'd12);
      check("add_zero", 32'(bus.resp_zero), 32'h0);
      check("add_err", 32'(bus.resp_err), 32'h0);
      check("add_op_count", 32'(op_count), 32'd1);
      @(posedge clk); #1;

      // Divide by zero from req2
      run_op(2, 5'd3, 32'd10, 32'd0, "div_wait");
      check("div_data", bus.resp_data, 32'hFFFF_FFFF);
      check("div_err", 32'(bus.resp_err), 32'h1);
      check("div_err_count", 32'(err_count), 32'd1);
      @(posedge clk); #1;

      // Backpressure on req1 subtract, req0 waiting behind it
      bus.resp_ready = 4'b1101;
      set_req(1, 5'd1, 32'd3, 32'd3);
      wait_ready(1, "bp_ready");
      @(posedge clk); #1;
      clr_req(1);
      set_req(0, 5'd0, 32'd20, 32'd22);
      wait_resp(1, "bp_resp");
      for (int k = 0; k < 10; k++) begin
         check("bp_valid", 32'(bus.resp_valid), 32'h2);
         check("bp_data", bus.resp_data, 32'h0);
         check("bp_zero", 32'(bus.resp_zero), 32'h1);
         check("bp_no_ready", 32'(bus.req_ready), 32'h0);
         if (k < 9) begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
      bus.resp_ready = '1;
      @(negedge clk);
      check("bp_release_valid", 32'(bus.resp_valid), 32'h2);
      check("bp_release_ready", 32'(bus.req_ready), 32'h0);
      @(negedge clk);
      check("bp_next_ready", 32'(bus.req_ready), 32'h1);
      @(posedge clk); #1;
      clr_req(0);
      wait_resp(0, "bp_follow");
      check("bp_follow_data", bus.resp_data, 32'd42);
      @(posedge clk); #1;

      // Round-robin fairness: all requesters valid for 16 operations
      do_reset();
      for (int i = 0; i < NR; i++) set_req(i, 5'(i), 32'(100 + i), 32'(i + 1));
      for (int k = 0; k < 16; k++) begin
         n = 0;
         @(negedge clk);
         while (bus.req_ready == '0 && n < 20) begin @(negedge clk); n++; end
         if (n >= 20) timeout("rr_wait");
         g = -1;
         for (int j = 0; j < NR; j++) if (((bus.req_ready >> j) & NR'(1)) != '0) g = j;
         check("rr_order", 32'(g), 32'(k % NR));
         if (g >= 0) served[g]++;
         @(posedge clk); #1;
         if (g >= 0) r_a[g] = r_a[g] + 32'd17;
      end
      bus.req_valid = '0;
      n = 0;
      @(negedge clk);
      while (busy && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) timeout("rr_drain");
      for (int i = 0; i < NR; i++) check("rr_count", 32'(served[i]), 32'd4);
      @(posedge clk); #1;

      // Counter wrap with a 4-bit counter
      do_reset();
      for (int k = 0; k < 17; k++) begin
         run_op(1, 5'd0, 32'(k), 32'd1, "wrap_wait");
         if (k == 15) check("wrap_at_16", 32'(op_count), 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("wrap_op_count", 32'(op_count), 32'd1);
      check("wrap_err_count", 32'(err_count), 32'd0);
      @(posedge clk); #1;

      // Reset during EXEC of an add from req3
      do_reset();
      set_req(3, 5'd0, 32'd1, 32'd2);
      @(negedge clk);
      check("mid_ready3", 32'(bus.req_ready), 32'h8);
      @(posedge clk); #1;
      clr_req(3);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("mid_busy", 32'(busy), 32'h0);
      check("mid_resp_valid", 32'(bus.resp_valid), 32'h0);
      check("mid_alu_sel", 32'(alu_sel), 32'h1F);
      check("mid_op_count", 32'(op_count), 32'd0);
      @(posedge clk); #1;
      set_req(0, 5'd6, 32'hF0F0, 32'h0FF0);
      set_req(3, 5'd7, 32'h8000_0000, 32'd4);
      @(negedge clk);
      check("mid_contend", 32'(bus.req_ready), 32'h1);
      @(posedge clk); #1;
      clr_req(0);
      wait_resp(0, "mid_r0");
      check("mid_xor", bus.resp_data, 32'hFF00);
      @(posedge clk); #1;
      wait_ready(3, "mid_r3_ready");
      @(posedge clk); #1;
      clr_req(3);
      wait_resp(3, "mid_r3");
      check("mid_sra", bus.resp_data, 32'hF800_0000);
      @(posedge clk); #1;
      repeat (2) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Round-robin scheduler that shares one processing-element ALU among `NUM_REQ` requesters (neighbour PEs, load/store path, local control) in the RISC-V CGRA PE. It accepts one operation at a time over a valid/ready handshake and drives the ALU's A, B and select inputs. It captures the registered ALU result and returns it with status flags to the granted requester. It also keeps wrapping operation and error counters for the PE's debug view.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CNT_W`, 16: width of the statistics counters.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clk`.
- `req_valid`  in  `NUM_REQ`  per-requester operation request.
- `req_ready`  out  `NUM_REQ`  one-hot accept; a transfer occurs when `req_valid[i]` and `req_ready[i]` are both high.
- `req_op`  in  `5*NUM_REQ`  ALU select for requester i, in bits `[5i+4:5i]`.
- `req_a`, `req_b`  in  `32*NUM_REQ`  operands for requester i, in bits `[32i+31:32i]`.
- `resp_valid`  out  `NUM_REQ`  one-hot; result available for the granted requester.
- `resp_ready`  in  `NUM_REQ`  the requester consumes the result.
- `resp_data`  out  32  captured ALU result.
- `resp_zero`  out  1  high when `resp_data == 0`; computed here from the captured data, never taken from the ALU's Zero output.
- `resp_cout`  out  1  ALU carry-out captured with the result.
- `resp_err`  out  1  high when ALUcomplete was low at capture (divide by zero, select 11111, or an unused select).
- `alu_a`, `alu_b`  out  32  registered operands to the ALU.
- `alu_sel`  out  5  registered ALU select; holds 5'b11111 (no-op) whenever no operation is in flight.
- `alu_out`  in  32  ALU_Out.
- `alu_complete`  in  1  ALUcomplete.
- `alu_cout`  in  1  Cout.
- `busy`  out  1  high in every state except IDLE.
- `op_count`, `err_count`  out  `CNT_W`  completed operations and completed operations with `resp_err` set; both wrap.

## Operation
- The FSM has four states: IDLE, ISSUE, EXEC and RESP.
- **IDLE**
  - The arbiter searches `req_valid` starting at index `(last_grant+1) mod NUM_REQ` and picks the first valid requester g.
  - `req_ready[g]` is asserted combinationally in the same cycle; all other `req_ready` bits stay low.
  - On the accepting edge: `alu_a`, `alu_b` and `alu_sel` load the operands and op of requester g, `last_grant` becomes g, and the FSM moves to ISSUE.
  - With no valid request the FSM stays in IDLE and `req_ready` is all zero.
- **ISSUE**
  - ALU inputs are held stable.
  - The ALU registers its result on the edge that ends this cycle.
  - The FSM always moves to EXEC.
- **EXEC**
  - `alu_out`, `alu_complete` and `alu_cout` are valid.
  - On the edge that ends this cycle:
    - `resp_data` loads `alu_out`;
    - `resp_err` loads `~alu_complete`;
    - `resp_cout` loads `alu_cout`;
    - `resp_zero` loads `(alu_out == 0)`;
    - `alu_sel` returns to 5'b11111;
    - `op_count` increments, and `err_count` increments when `alu_complete` is 0;
    - the FSM moves to RESP.
- **RESP**
  - `resp_valid[last_grant]` is 1; `resp_*` are held stable.
  - When `resp_ready[last_grant]` is high, the FSM returns to IDLE on that edge and `resp_valid` drops.
  - `resp_ready` bits of other requesters are ignored.
  - No new request is accepted in RESP: at most one operation is outstanding.
- Requests are never dropped. A requester holding `req_valid` waits at most `NUM_REQ-1` other grants.
- Counters wrap from `2^CNT_W-1` to 0.

## Timing
- Reset (`reset` low at a rising edge):
  - FSM goes to IDLE and `last_grant` is set to `NUM_REQ-1`, so requester 0 has first priority.
  - `req_ready`, `resp_valid`, `busy`, `resp_data`, `resp_zero`, `resp_cout`, `resp_err`, `op_count` and `err_count` are all 0.
  - `alu_a` and `alu_b` are 0; `alu_sel` is 5'b11111.
- Reset asserted in any state aborts the in-flight operation. No response is issued and the counters are not incremented.
- Latency: accept edge at cycle N, `resp_valid` high in cycle N+3. With `resp_ready` already high, the next accept is possible in cycle N+4.
- Throughput: one operation per 4 cycles when `resp_ready` is tied high.
- `req_op`, `req_a` and `req_b` are sampled only on the accepting edge; later changes are ignored.
- If requester g deasserts `req_valid` in IDLE before being accepted, no grant is made. `req_valid` is not required to stay high.
- The ALU's SRA and divide paths are registered in a single cycle. The EXEC capture relies on that single-cycle ALU latency.

## Test plan
- **Single add:** after reset, req0 sends op 5'b00000, A=5, B=7. Required: `req_ready[0]` high in cycle N, `resp_valid[0]` high in N+3 with `resp_data`=12, `resp_zero`=0, `resp_err`=0, and `op_count`=1.
- **Divide by zero:** req2 sends op 5'b00011, A=10, B=0. Required: `resp_data`=0xFFFFFFFF, `resp_err`=1, and `err_count`=1.
- **Round-robin fairness:** all four `req_valid` held high for 16 operations. Required grant order 0,1,2,3,0,1,2,3,… with each requester served exactly 4 times.
- **Response backpressure:** `resp_ready[1]` held low for 10 cycles during a subtract, A=3, B=3. Required: `resp_valid[1]` and `resp_data`=0 with `resp_zero`=1 stay stable, and no `req_ready` is asserted until the cycle after `resp_ready[1]` rises.
- **Reset mid-operation:** `reset` driven low in EXEC of an add from req3. Required next cycle: IDLE, `resp_valid`=0, `alu_sel`=5'b11111, and `op_count`=0; a subsequent req0 and req3 contention grants req0 first.
- **Counter wrap:** with `CNT_W`=4, run 17 operations. Required `op_count`=1.
